addsub_bcd_seq: RTL and testbench



---
 rtl/addsub_bcd_seq.sv | 122 ++++++++++++
 tb/tb_addsub_bcd_seq.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/addsub_bcd_seq.sv
// addsub_bcd_seq: unsigned add/subtract with signed-magnitude BCD and 7-segment output
module addsub_bcd_seq #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sel,
  input  logic [WIDTH-1:0]      A,
  input  logic [WIDTH-1:0]      B,
  output logic                  busy,
  output logic                  done,
  output logic                  negative,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic [6:0]            seg_sign
);
  localparam int MW = WIDTH + 1;
  localparam int CW = $clog2(MW + 1);
  localparam logic [6:0] SEG_BLANK = 7'h7f;
  localparam logic [6:0] SEG_MINUS = 7'h3f;
  typedef enum logic [1:0] {IDLE, CONV, FINISH} state_t;
  state_t              state_q, state_d;
  logic [MW-1:0]       shift_q, shift_d, mag;
  logic [4*DIGITS-1:0] scr_q, scr_d, adj, bcd_q, bcd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                sign_q, sign_d, neg_q, neg_d, done_q, done_d;
  logic [7*DIGITS-1:0] seg_q, seg_d;
  logic [6:0]          seg_sign_q, seg_sign_d;
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction
  // Walk from the top digit down so z tracks "this and every higher digit is zero"
  function automatic logic [7*DIGITS-1:0] seg_word(input logic [4*DIGITS-1:0] b);
    logic z;
    z = 1'b1;
    seg_word = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      z = z && (b[4*i +: 4] == 4'd0);
      seg_word[7*i +: 7] = (BLANK_LZ != 0 && i > 0 && z) ? SEG_BLANK : seg7(b[4*i +: 4]);
    end
  endfunction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scr_q      <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      neg_q      <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      seg_q      <= seg_word('0);
      seg_sign_q <= SEG_BLANK;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scr_q      <= scr_d;
      cnt_q      <= cnt_d;
      sign_q     <= sign_d;
      neg_q      <= neg_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      seg_q      <= seg_d;
      seg_sign_q <= seg_sign_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE ? (start ? CONV : IDLE) :
              state_q == CONV ? (cnt_q == CW'(WIDTH) ? FINISH : CONV) : IDLE;
  end
  always_comb begin
    mag = sel ? (A >= B ? {1'b0, A} - {1'b0, B} : {1'b0, B} - {1'b0, A}) : {1'b0, A} + {1'b0, B};
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = scr_q[4*i +: 4] >= 4'd5 ? scr_q[4*i +: 4] + 4'd3 : scr_q[4*i +: 4];
    shift_d    = shift_q;
    scr_d      = scr_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    neg_d      = neg_q;
    bcd_d      = bcd_q;
    seg_d      = seg_q;
    seg_sign_d = seg_sign_q;
    done_d     = state_q == FINISH;
    if (state_q == IDLE && start) begin
      shift_d = mag;
      scr_d   = '0;
      cnt_d   = '0;
      sign_d  = sel && (A < B);
    end
    if (state_q == CONV) begin
      {scr_d, shift_d} = {adj, shift_q} << 1;
      cnt_d = cnt_q + 1'b1;
    end
    if (state_q == FINISH) begin
      bcd_d      = scr_q;
      neg_d      = sign_q;
      seg_d      = seg_word(scr_q);
      seg_sign_d = sign_q ? SEG_MINUS : SEG_BLANK;
    end
  end
  assign busy     = state_q != IDLE;
  assign done     = done_q;
  assign negative = neg_q;
  assign bcd      = bcd_q;
  assign seg      = seg_q;
  assign seg_sign = seg_sign_q;
endmodule

// File: tb/tb_addsub_bcd_seq.sv
// tb_addsub_bcd_seq: directed checks of the add/sub BCD display block at 8 and 12 bits
module tb_addsub_bcd_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic        start8 = 1'b0, sel8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, neg8;
  logic [11:0] bcd8;
  logic [20:0] seg8;
  logic [6:0]  sgn8;
  logic        start12 = 1'b0, sel12 = 1'b0;
  logic [11:0] a12 = '0, b12 = '0;
  logic        busy12, done12, neg12;
  logic [15:0] bcd12;
  logic [27:0] seg12;
  logic [6:0]  sgn12;
  addsub_bcd_seq u8 (
    .clk(clk), .rst(rst), .start(start8), .sel(sel8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .negative(neg8), .bcd(bcd8), .seg(seg8), .seg_sign(sgn8)
  );
  addsub_bcd_seq #(.WIDTH(12), .DIGITS(4), .BLANK_LZ(0)) u12 (
    .clk(clk), .rst(rst), .start(start12), .sel(sel12), .A(a12), .B(b12),
    .busy(busy12), .done(done12), .negative(neg12), .bcd(bcd12), .seg(seg12), .seg_sign(sgn12)
  );
  int passed = 0, failed = 0, total = 0;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  // Returns the number of edges after the accepting edge until done is seen
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s, output int n);
    a8 = a; b8 = b; sel8 = s; start8 = 1'b1;
    step;
    start8 = 1'b0;
    n = 0;
    do begin step; n++; end while (!done8 && n < 40);
  endtask
  task automatic run12(input logic [11:0] a, input logic [11:0] b, input logic s, output int n);
    a12 = a; b12 = b; sel12 = s; start12 = 1'b1;
    step;
    start12 = 1'b0;
    n = 0;
    do begin step; n++; end while (!done12 && n < 40);
  endtask
  initial begin
    int n, nd, first, d1, d2;
    step; step;
    rst = 1'b0;
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_neg8", neg8, 0);
    chk("rst_bcd8", bcd8, 0);
    chk("rst_seg8", seg8, {7'h7f, 7'h7f, 7'h40});
    chk("rst_sgn8", sgn8, 7'h7f);
    chk("rst_seg12", seg12, {7'h40, 7'h40, 7'h40, 7'h40});
    run8(200, 55, 0, n);
    chk("add_lat", n, 10);
    chk("add_bcd", bcd8, 12'h255);
    chk("add_neg", neg8, 0);
    chk("add_sgn", sgn8, 7'h7f);
    chk("add_seg", seg8, {7'h24, 7'h12, 7'h12});
    step;
    chk("done_pulse", done8, 0);
    chk("hold_bcd", bcd8, 12'h255);
    run8(255, 255, 0, n);
    chk("max_bcd", bcd8, 12'h510);
    chk("max_seg", seg8, {7'h12, 7'h79, 7'h40});
    run8(0, 0, 0, n);
    chk("zero_bcd", bcd8, 12'h000);
    chk("zero_seg", seg8, {7'h7f, 7'h7f, 7'h40});
    run8(3, 10, 1, n);
    chk("sub_neg", neg8, 1);
    chk("sub_bcd", bcd8, 12'h007);
    chk("sub_sgn", sgn8, 7'h3f);
    chk("sub_seg", seg8, {7'h7f, 7'h7f, 7'h78});
    a8 = 50; b8 = 50; sel8 = 0; start8 = 1'b1;
    step;
    start8 = 1'b0;
    step; step; step;
    rst = 1'b1; start8 = 1'b1;
    step;
    rst = 1'b0; start8 = 1'b0;
    chk("mid_rst_busy", busy8, 0);
    chk("mid_rst_done", done8, 0);
    chk("mid_rst_bcd", bcd8, 0);
    chk("mid_rst_neg", neg8, 0);
    chk("mid_rst_seg", seg8, {7'h7f, 7'h7f, 7'h40});
    chk("mid_rst_sgn", sgn8, 7'h7f);
    nd = 0;
    for (int i = 0; i < 15; i++) begin step; if (done8) nd++; end
    chk("mid_rst_nodone", nd, 0);
    run8(50, 50, 0, n);
    chk("post_rst_lat", n, 10);
    chk("post_rst_bcd", bcd8, 12'h100);
    chk("post_rst_seg", seg8, {7'h79, 7'h40, 7'h40});
    run8(77, 77, 1, n);
    chk("eq_bcd", bcd8, 0);
    chk("eq_neg", neg8, 0);
    chk("eq_sgn", sgn8, 7'h7f);
    a8 = 1; b8 = 2; sel8 = 0; start8 = 1'b1;
    step;
    chk("busy_after_start", busy8, 1);
    nd = 0; first = 0;
    for (int i = 1; i <= 24; i++) begin
      start8 = (i == 1 || i == 5);
      a8 = 9;
      step;
      start8 = 1'b0;
      if (done8) begin nd++; if (first == 0) first = i; end
    end
    chk("ign_count", nd, 1);
    chk("ign_lat", first, 10);
    chk("ign_bcd", bcd8, 12'h003);
    run8(10, 20, 1, n);
    chk("b2b_first_bcd", bcd8, 12'h010);
    chk("b2b_first_seg", seg8, {7'h7f, 7'h79, 7'h40});
    chk("b2b_done_high", done8, 1);
    run8(100, 1, 0, n);
    chk("b2b_lat", n, 10);
    chk("b2b_bcd", bcd8, 12'h101);
    chk("b2b_neg", neg8, 0);
    a8 = 4; b8 = 4; sel8 = 0; start8 = 1'b1;
    d1 = 0; d2 = 0;
    for (int i = 1; i <= 30; i++) begin
      step;
      if (done8) begin if (d1 == 0) d1 = i; else if (d2 == 0) d2 = i; end
    end
    start8 = 1'b0;
    chk("cont_period", d2 - d1, 11);
    chk("cont_bcd", bcd8, 12'h008);
    for (int i = 0; i < 15; i++) step;
    run12(4095, 4095, 0, n);
    chk("w12_lat", n, 14);
    chk("w12_bcd", bcd12, 16'h8190);
    chk("w12_seg", seg12, {7'h00, 7'h79, 7'h10, 7'h40});
    run12(0, 5, 1, n);
    chk("w12_sub_bcd", bcd12, 16'h0005);
    chk("w12_sub_neg", neg12, 1);
    chk("w12_sub_sgn", sgn12, 7'h3f);
    chk("w12_sub_seg", seg12, {7'h40, 7'h40, 7'h40, 7'h12});
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
